// File: rtl/rr_arbiter_8to1_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter:
// requester count, default widths/limits, FSM encoding and the
// rotating-priority search helper.
package rr_arbiter_8to1_pkg;

  localparam int NREQ        = 8;
  localparam int N_DEF       = 32;
  localparam int MAXHOLD_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req, scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [2:0]      ptr);
    pick_t      r;
    logic [2:0] k;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      k = ptr + 3'(i);
      if (!r.found && req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_8to1_mux.sv
// 8:1 N-bit data mux. Input slice i sits at [N*(8-i)-1 : N*(7-i)],
// so requester 0 is the most significant slice.
module Mux8to1_32Bit
  import rr_arbiter_8to1_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [2:0]        sel_i,
  input  logic [NREQ*N-1:0] data_i,
  output logic [N-1:0]      data_o
);

  logic [N-1:0] slices [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slices[g] = data_i[N*(NREQ-g)-1 -: N];
  end

  // Pick the slice addressed by sel_i.
  always_comb begin
    data_o = slices[sel_i];
  end

endmodule

// File: rtl/rr_arbiter_8to1.sv
// Round-robin arbiter for 8 requesters with a bounded hold time.
// A winner keeps the grant while it requests, up to MAXHOLD cycles when
// someone else is waiting; the search for the next winner starts one
// past the last granted index. Grant outputs are registered; the data
// output is a combinational mux of the granted requester's slice.
module rr_arbiter_8to1
  import rr_arbiter_8to1_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MAXHOLD = MAXHOLD_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*N-1:0] IN_DATA,
  output logic [NREQ-1:0]   GNT,
  output logic [2:0]        SEL,
  output logic              VALID,
  output logic [N-1:0]      OUT_DATA
);

  localparam int              HW        = $clog2(MAXHOLD);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAXHOLD - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [2:0]      sel_q,   sel_d;
  logic            valid_q, valid_d;
  logic [2:0]      ptr_q,   ptr_d;
  logic [HW-1:0]   hold_q,  hold_d;

  logic [NREQ-1:0] arb_req;
  pick_t           pick;
  logic            do_arb;
  logic [N-1:0]    mux_data;

  // Next-state logic: hold, re-arbitrate or drop to idle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    do_arb  = 1'b0;

    // The current owner never wins a re-arbitration against itself.
    arb_req = REQ;
    if (state_q == ST_BUSY) arb_req[sel_q] = 1'b0;
    pick = rr_pick(arb_req, ptr_q);

    case (state_q)
      ST_IDLE: do_arb = 1'b1;
      ST_BUSY: begin
        if (REQ[sel_q] && (hold_q < HOLD_LAST)) hold_d = hold_q + HW'(1);
        else                                    do_arb = 1'b1;
      end
      default: do_arb = 1'b1;
    endcase

    if (do_arb) begin
      if (pick.found) begin
        state_d = ST_BUSY;
        gnt_d   = NREQ'(1) << pick.idx;
        sel_d   = pick.idx;
        valid_d = 1'b1;
        ptr_d   = pick.idx + 3'd1;
        hold_d  = '0;
      end else if (!((state_q == ST_BUSY) && REQ[sel_q])) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        sel_d   = 3'd0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
      // Otherwise the owner is alone and keeps the grant, count saturated.
    end
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  Mux8to1_32Bit #(.N(N)) u_mux (
    .sel_i  (sel_q),
    .data_i (IN_DATA),
    .data_o (mux_data)
  );

  assign GNT      = gnt_q;
  assign SEL      = sel_q;
  assign VALID    = valid_q;
  assign OUT_DATA = valid_q ? mux_data : '0;

endmodule

// File: doc/rr_arbiter_8to1.md
RR_ARBITER_8TO1 -- requirements
Module: rr_arbiter_8to1

Interface
REQ-001 Parameter N, default 32, data width per requester.
REQ-002 Parameter MAXHOLD, default 8, maximum consecutive grant cycles while another request is pending (legal range 2..16).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ  input  8  request vector; bit i = requester i.
REQ-006 IN_DATA  input  8*N  packed requester data; requester i occupies bits [N*(8-i)-1 : N*(7-i)], so requester 0 is the MSB slice.
REQ-007 GNT  output  8  one-hot registered grant; all zero when idle.
REQ-008 SEL  output  3  registered binary index of the granted requester.
REQ-009 VALID  output  1  registered; high when a grant is active.
REQ-010 OUT_DATA  output  N  data of the granted requester; all zero when VALID=0.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 IDLE: if REQ≠0, the block SHALL grant the first set REQ bit searching PTR, PTR+1, ... mod 8 and enter BUSY; otherwise it SHALL stay in IDLE.
REQ-013 Grant latency SHALL be one cycle: REQ sampled at edge k drives GNT/SEL/VALID after edge k.
REQ-014 On every new grant to index g, the block SHALL set PTR=(g+1) mod 8, wrapping 7 to 0, and clear HOLDCNT to 0.
REQ-015 BUSY, REQ[cur]=1, HOLDCNT<MAXHOLD-1: the block SHALL hold the grant and increment HOLDCNT.
REQ-016 BUSY, REQ[cur]=1, HOLDCNT=MAXHOLD-1, other REQ bits set: the block SHALL re-arbitrate from PTR with cur excluded and grant the winner in the next cycle, without an idle cycle.
REQ-017 BUSY, REQ[cur]=1, HOLDCNT=MAXHOLD-1, no other request: the block SHALL keep the grant with HOLDCNT saturated.
REQ-018 BUSY, REQ[cur]=0: if any other REQ bit is set, the block SHALL re-arbitrate from PTR and grant the winner in the next cycle; otherwise it SHALL return to IDLE with GNT=0, VALID=0.
REQ-019 SEL SHALL always equal the index of the GNT bit; GNT SHALL never have more than one bit set.
REQ-020 OUT_DATA SHALL be combinational from SEL and IN_DATA, gated by VALID.
REQ-021 Requests arriving during BUSY SHALL have no effect until the next arbitration point (REQ-016/REQ-018).

Reset
REQ-022 RST=1 at a rising edge SHALL force state=IDLE, GNT=0, SEL=0, VALID=0, PTR=0, HOLDCNT=0, overriding any in-progress grant.
REQ-023 The first arbitration after RST is released SHALL use PTR=0.

Structure
REQ-024 A shared package/header SHALL hold the requester count (8), N, MAXHOLD, and the IDLE/BUSY state encodings.
REQ-025 The data path SHALL instantiate the existing 8:1 N-bit mux (Mux8to1_32Bit) as the single sub-module, driven by SEL; the arbiter logic SHALL stay in rr_arbiter_8to1.
REQ-026 HOLDCNT SHALL be ceil(log2(MAXHOLD)) bits wide; PTR SHALL be 3 bits wide.

Verification
REQ-027 Reset, then REQ=8'h00 for 5 cycles -> GNT=0, VALID=0, OUT_DATA=0.
REQ-028 REQ=8'h24 (bits 2 and 5) held, MAXHOLD=8 -> grant 2 for 8 cycles, then grant 5 for 8 cycles, then grant 2; SEL follows 2, 5, 2.
REQ-029 REQ[3] pulses 1 cycle from IDLE with IN_DATA slice 3=32'hDEADBEEF -> one cycle later GNT=8'h08, SEL=3, OUT_DATA=32'hDEADBEEF for 1 cycle, then VALID=0.
REQ-030 PTR=7 after granting 6, REQ=8'h81 -> grant 7 first, then 0 (wrap-around).
REQ-031 RST asserted mid-grant at HOLDCNT=4 on requester 6 -> next cycle GNT=0, VALID=0; after release with REQ=8'h41, grant goes to 0.
REQ-032 REQ=8'h01 only, held 20 cycles -> GNT=8'h01 continuously with no gap (HOLDCNT saturates).
